min_bound_accumulator: RTL and testbench

- Sequential counterpart of the lower-bound maximum tree. Accepts a serial stream of candidate bounds, each carrying a value, an activation flag and a sign flag, and reduces one frame to the minimum of all active upper-bound candidates (activation=1, sign=1).
- The result is the upper bound that feeds the MCMC variable-range logic.
- One candidate is accepted per cycle under a valid/ready handshake. The result is held under a second valid/ready handshake.

---
 rtl/min_max_pkg.sv | 16 +
 rtl/min_candidate_select.sv | 24 ++
 rtl/min_bound_accumulator.sv | 116 +++++++++++
 tb/tb_min_bound_accumulator.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/min_max_pkg.sv
// Shared types and helpers for the min/max bound reduction blocks.
package min_max_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

  // Largest positive two's-complement value representable in width bits (width <= 32).
  function automatic int signed_max(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

endpackage

// File: rtl/min_candidate_select.sv
// Combinational compare cell: folds one candidate into a running minimum.
module min_candidate_select
  import min_max_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic signed [WIDTH-1:0] held_min,
  input  logic                    held_act,
  input  logic signed [WIDTH-1:0] value,
  input  logic                    activation,
  input  logic                    sign,
  output logic signed [WIDTH-1:0] next_min,
  output logic                    next_act,
  output logic                    qualify
);

  always_comb begin
    qualify  = activation & sign;
    // Strict less-than keeps the held value on a tie.
    next_min = (qualify && (value < held_min)) ? value : held_min;
    next_act = held_act | qualify;
  end

endmodule

// File: rtl/min_bound_accumulator.sv
// Serial reduction of one frame of candidates to the minimum active upper bound.
module min_bound_accumulator
  import min_max_pkg::*;
#(
  parameter  int WIDTH     = WIDTH_DEFAULT,
  parameter  int MAX_COUNT = 16,
  localparam int CW        = $clog2(MAX_COUNT + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_value,
  input  logic                    in_activation,
  input  logic                    in_sign,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_minimum,
  output logic                    out_activation,
  output logic [CW-1:0]           out_count,
  output logic                    out_overflow
);

  localparam logic signed [WIDTH-1:0] MAX_VAL = WIDTH'(signed_max(WIDTH));
  localparam logic [CW-1:0]           MAX_CNT = CW'(MAX_COUNT);

  acc_state_t state_q, state_d;

  logic signed [WIDTH-1:0] acc_min;
  logic                    acc_act;
  logic [CW-1:0]           acc_qcnt;
  logic [CW-1:0]           acc_beats;
  logic                    acc_ovf;

  logic signed [WIDTH-1:0] min_nxt;
  logic                    act_nxt;
  logic                    qualify;
  logic [CW-1:0]           qcnt_nxt;
  logic [CW-1:0]           beats_nxt;
  logic                    ovf_nxt;
  logic                    accept;

  min_candidate_select #(.WIDTH(WIDTH)) u_select (
    .held_min   (acc_min),
    .held_act   (acc_act),
    .value      (in_value),
    .activation (in_activation),
    .sign       (in_sign),
    .next_min   (min_nxt),
    .next_act   (act_nxt),
    .qualify    (qualify)
  );

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_d = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_comb begin
    accept    = in_valid & in_ready;
    qcnt_nxt  = (qualify && (acc_qcnt != MAX_CNT)) ? acc_qcnt + CW'(1) : acc_qcnt;
    beats_nxt = (acc_beats != MAX_CNT) ? acc_beats + CW'(1) : acc_beats;
    ovf_nxt   = acc_ovf | (acc_beats == MAX_CNT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ACCUM;
      acc_min        <= MAX_VAL;
      acc_act        <= 1'b0;
      acc_qcnt       <= '0;
      acc_beats      <= '0;
      acc_ovf        <= 1'b0;
      out_minimum    <= MAX_VAL;
      out_activation <= 1'b0;
      out_count      <= '0;
      out_overflow   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        if (in_last) begin
          // Publish including the last beat, then start the next frame clean.
          out_minimum    <= min_nxt;
          out_activation <= act_nxt;
          out_count      <= qcnt_nxt;
          out_overflow   <= ovf_nxt;
          acc_min        <= MAX_VAL;
          acc_act        <= 1'b0;
          acc_qcnt       <= '0;
          acc_beats      <= '0;
          acc_ovf        <= 1'b0;
        end else begin
          acc_min   <= min_nxt;
          acc_act   <= act_nxt;
          acc_qcnt  <= qcnt_nxt;
          acc_beats <= beats_nxt;
          acc_ovf   <= ovf_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_min_bound_accumulator.sv
// Directed bench for min_bound_accumulator with hand-computed expectations.
module tb_min_bound_accumulator;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] in_value;
  logic              in_activation;
  logic              in_sign;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] out_minimum;
  logic              out_activation;
  logic [4:0]        out_count;
  logic              out_overflow;

  int pass_cnt = 0;
  int total_cnt = 0;

  min_bound_accumulator #(.WIDTH(8), .MAX_COUNT(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_value       (in_value),
    .in_activation  (in_activation),
    .in_sign        (in_sign),
    .in_last        (in_last),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_minimum    (out_minimum),
    .out_activation (out_activation),
    .out_count      (out_count),
    .out_overflow   (out_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    assert (got === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, $signed(got), got,
             $signed(exp), exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic signed [7:0] v, input logic a, input logic s,
                           input logic l);
    int waited;
    in_valid      = 1'b1;
    in_value      = v;
    in_activation = a;
    in_sign       = s;
    in_last       = l;
    waited = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!in_ready) check("in_ready_wait", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic signed [7:0] min_exp,
                               input logic act_exp, input int cnt_exp, input logic ovf_exp);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_min"}, 32'(out_minimum), 32'(min_exp));
    check({tag, "_act"}, 32'(out_activation), 32'(act_exp));
    check({tag, "_cnt"}, 32'(out_count), 32'(cnt_exp));
    check({tag, "_ovf"}, 32'(out_overflow), 32'(ovf_exp));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_value = '0;
    in_activation = 1'b0;
    in_sign = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_min", 32'(out_minimum), 32'(127));
    check("rst_act", 32'(out_activation), 32'd0);
    check("rst_cnt", 32'(out_count), 32'd0);
    check("rst_ovf", 32'(out_overflow), 32'd0);

    // Basic minimum over three qualifying beats
    send_beat(8'sd5, 1, 1, 0);
    send_beat(-8'sd3, 1, 1, 0);
    check("f1_mid_valid", 32'(out_valid), 32'd0);
    send_beat(8'sd7, 1, 1, 1);
    expect_result("f1", -8'sd3, 1, 3, 0);

    // Lower-bound and inactive beats ignored
    send_beat(-8'sd100, 1, 0, 0);
    send_beat(-8'sd50, 0, 1, 0);
    send_beat(8'sd20, 1, 1, 1);
    expect_result("f2", 8'sd20, 1, 1, 0);

    // Empty qualifying set
    send_beat(8'sd10, 0, 1, 1);
    expect_result("f3", 8'sd127, 0, 0, 0);

    // Back-pressure: second frame held while the first result waits
    send_beat(8'sd3, 1, 1, 1);
    in_valid = 1'b1;
    in_value = -8'sd128;
    in_activation = 1'b1;
    in_sign = 1'b1;
    in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_held_min", 32'(out_minimum), 32'(3));
      tick();
    end
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_cnt", 32'(out_count), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_accum_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
    expect_result("f5", -8'sd128, 1, 1, 0);

    // Exactly MAX_COUNT beats: full count, no overflow
    for (int i = 0; i < 16; i++) send_beat(8'sd2, 1, 1, (i == 15));
    expect_result("f16", 8'sd2, 1, 16, 0);

    // MAX_COUNT+1 beats: saturated count and overflow
    for (int i = 0; i < 17; i++) send_beat(8'sd1, 1, 1, (i == 16));
    expect_result("f17", 8'sd1, 1, 16, 1);

    // Mid-frame reset discards the partial frame
    send_beat(-8'sd9, 1, 1, 0);
    send_beat(8'sd4, 1, 1, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_valid", 32'(out_valid), 32'd0);
    check("rst2_min", 32'(out_minimum), 32'(127));
    send_beat(8'sd6, 1, 1, 1);
    expect_result("f6", 8'sd6, 1, 1, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
